// File: rtl/cos_nco_pkg.sv
// Shared types and constants for the cosine NCO stage.
// The quarter-wave table contents are generated at elaboration by cos_entry().
package cos_nco_pkg;

    localparam int DEF_PHASE_W = 32;
    localparam int DEF_LUT_AW  = 8;
    localparam int DEF_AMP_W   = 16;

    typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_e;
    typedef enum logic {IDLE, RUN} state_e;

    // 16-bit maximal LFSR, taps 16,14,13,11 as a bit mask over [15:0]
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // round(fs * cos(pi/2 * k/n)) via a Taylor series, so no math library is needed
    function automatic int cos_entry(int k, int n, int amp_w);
        real x, x2, term, sum, fs;
        x    = 1.5707963267948966 * real'(k) / real'(n);
        x2   = x * x;
        term = 1.0;
        sum  = 1.0;
        for (int j = 1; j <= 14; j++) begin
            term = -term * x2 / real'((2 * j - 1) * (2 * j));
            sum  = sum + term;
        end
        fs = real'((1 << (amp_w - 1)) - 1);
        return $rtoi(fs * sum + 0.5);
    endfunction

endpackage

// File: rtl/cos_quarter_lut.sv
// Quarter-wave cosine ROM, 2^LUT_AW+1 unsigned magnitudes, one-cycle registered read.
module cos_quarter_lut
    import cos_nco_pkg::*;
#(
    parameter int LUT_AW = DEF_LUT_AW,
    parameter int AMP_W  = DEF_AMP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LUT_AW:0]   addr,
    output logic [AMP_W-2:0]  data
);

    localparam int N = 1 << LUT_AW;

    logic [AMP_W-2:0] rom [N+1];
    logic [AMP_W-2:0] data_q, data_d;

    for (genvar k = 0; k <= N; k++) begin : g_rom
        localparam int V = cos_entry(k, N, AMP_W);
        assign rom[k] = (AMP_W-1)'(V);
    end

    always_comb data_d = rom[addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_q <= '0;
        else        data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/cos_nco_stage.sv
// Frame-synchronous cosine NCO: increments are staged and applied only on frame_start.
// Optional phase dither before truncation is enabled by defining COS_NCO_DITHER_EN.
module cos_nco_stage
    import cos_nco_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int LUT_AW  = DEF_LUT_AW,
    parameter int AMP_W   = DEF_AMP_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PHASE_W-1:0] inc_data,
    input  logic               inc_valid,
    output logic               inc_ready,
    input  logic               frame_start,
    input  logic               sample_en,
    output logic [AMP_W-1:0]   cos_data,
    output logic               cos_valid,
    output logic [PHASE_W-1:0] phase_out,
    output logic               running
);

    localparam int STAGES = 3;
    localparam int IDX_W  = LUT_AW + 2;
    localparam logic [LUT_AW:0] N_ADDR = {1'b1, {LUT_AW{1'b0}}};

    state_e             state_q, state_d;
    logic               pend_full_q, pend_full_d;
    logic [PHASE_W-1:0] pend_q, pend_d;
    logic [PHASE_W-1:0] act_inc_q, act_inc_d;
    logic [PHASE_W-1:0] acc_q, acc_d;
    logic               load, xfer, samp;

    logic [STAGES:1]    vld_pipe_q, vld_pipe_d;
    logic [PHASE_W-1:0] ph1_q, ph1_d, ph2_q, ph2_d;
    logic [IDX_W-1:0]   idx1_q, idx1_d;
    logic [IDX_W-1:0]   samp_idx;
    logic               neg2_q, neg2_d;
    logic [AMP_W-1:0]   cos_q, cos_d;
    logic [PHASE_W-1:0] phase_out_q, phase_out_d;

    quad_e              quad;
    logic [LUT_AW-1:0]  lut_i;
    logic [LUT_AW:0]    lut_addr;
    logic [AMP_W-2:0]   lut_data;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (load) state_d = RUN;
    end

    always_comb running = (state_q == RUN);

    // ---------------- control / accumulator ----------------
    // Load wins over a same-cycle strobe; pending state is the pre-edge value.
    always_comb begin
        load        = frame_start && pend_full_q;
        xfer        = inc_valid && !pend_full_q;
        samp        = (state_q == RUN) && sample_en && !load;
        pend_full_d = pend_full_q;
        pend_d      = pend_q;
        act_inc_d   = act_inc_q;
        acc_d       = acc_q;
        if (load) begin
            act_inc_d   = pend_q;
            pend_full_d = 1'b0;
            acc_d       = '0;
        end else if (samp) begin
            acc_d = acc_q + act_inc_q;
        end
        if (xfer) begin
            pend_d      = inc_data;
            pend_full_d = 1'b1;
        end
    end

`ifdef COS_NCO_DITHER_EN
    localparam int DITH_W = PHASE_W - 2 - LUT_AW;
    localparam logic [PHASE_W-1:0] DITH_MASK = (PHASE_W'(1) << DITH_W) - PHASE_W'(1);

    logic [15:0]        lfsr_q, lfsr_d;
    logic [PHASE_W-1:0] dith_phase;

    always_comb begin
        lfsr_d     = sample_en ? {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)} : lfsr_q;
        dith_phase = acc_q + (PHASE_W'(lfsr_q) & DITH_MASK);
        samp_idx   = dith_phase[PHASE_W-1 -: IDX_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= lfsr_d;
    end
`else
    always_comb samp_idx = acc_q[PHASE_W-1 -: IDX_W];
`endif

    // ---------------- pipeline ----------------
    // S1 keeps the raw phase for phase_out beside the (possibly dithered) table index.
    always_comb begin
        vld_pipe_d = {vld_pipe_q[STAGES-1:1], samp};
        ph1_d      = samp ? acc_q : ph1_q;
        idx1_d     = samp ? samp_idx : idx1_q;
        ph2_d      = vld_pipe_q[1] ? ph1_q : ph2_q;
        quad       = quad_e'(idx1_q[IDX_W-1:LUT_AW]);
        lut_i      = idx1_q[LUT_AW-1:0];
        case (quad)
            Q0, Q2:  lut_addr = {1'b0, lut_i};
            default: lut_addr = N_ADDR - {1'b0, lut_i};
        endcase
        neg2_d      = vld_pipe_q[1] ? (quad == Q1 || quad == Q2) : neg2_q;
        cos_d       = vld_pipe_q[2] ? (neg2_q ? -{1'b0, lut_data} : {1'b0, lut_data}) : cos_q;
        phase_out_d = vld_pipe_q[2] ? ph2_q : phase_out_q;
    end

    cos_quarter_lut #(
        .LUT_AW (LUT_AW),
        .AMP_W  (AMP_W)
    ) u_lut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (lut_addr),
        .data  (lut_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_full_q <= 1'b0;
            pend_q      <= '0;
            act_inc_q   <= '0;
            acc_q       <= '0;
            vld_pipe_q  <= '0;
            ph1_q       <= '0;
            idx1_q      <= '0;
            ph2_q       <= '0;
            neg2_q      <= 1'b0;
            cos_q       <= '0;
            phase_out_q <= '0;
        end else begin
            pend_full_q <= pend_full_d;
            pend_q      <= pend_d;
            act_inc_q   <= act_inc_d;
            acc_q       <= acc_d;
            vld_pipe_q  <= vld_pipe_d;
            ph1_q       <= ph1_d;
            idx1_q      <= idx1_d;
            ph2_q       <= ph2_d;
            neg2_q      <= neg2_d;
            cos_q       <= cos_d;
            phase_out_q <= phase_out_d;
        end
    end

    assign inc_ready = !pend_full_q;
    assign cos_data  = cos_q;
    assign cos_valid = vld_pipe_q[STAGES];
    assign phase_out = phase_out_q;

endmodule

// File: tb/tb_cos_nco_stage.sv
// Self-checking bench for cos_nco_stage: constant vector table, directed corner
// sequences and a randomized run against a trig-based reference model.
module tb_cos_nco_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inc_data = '0;
    logic        inc_valid = 1'b0;
    logic        inc_ready;
    logic        frame_start = 1'b0;
    logic        sample_en = 1'b0;
    logic [15:0] cos_data;
    logic        cos_valid;
    logic [31:0] phase_out;
    logic        running;

    cos_nco_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc_data    (inc_data),
        .inc_valid   (inc_valid),
        .inc_ready   (inc_ready),
        .frame_start (frame_start),
        .sample_en   (sample_en),
        .cos_data    (cos_data),
        .cos_valid   (cos_valid),
        .phase_out   (phase_out),
        .running     (running)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    bit          m_pend, m_run, last_xfer;
    logic [31:0] m_pv, m_act, m_acc;
    bit          hv [3];
    logic [31:0] hp [3];

    typedef struct {
        logic [31:0] inc;
        logic        iv, fs, se;
        logic        e_rdy, e_run, e_cv;
        int          e_cos;
        logic [31:0] e_ph;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endtask

    // ideal cosine of the truncated phase: top 10 bits of the 32-bit phase
    function automatic int exp_cos(input logic [31:0] ph);
        real a, v;
        a = 2.0 * 3.14159265358979323846 * real'(ph >> 22) / 1024.0;
        v = 32767.0 * $cos(a);
        return int'($floor(v + 0.5));
    endfunction

    task automatic model_reset();
        m_pend = 0; m_run = 0; last_xfer = 0;
        m_pv = '0; m_act = '0; m_acc = '0;
        for (int i = 0; i < 3; i++) begin hv[i] = 0; hp[i] = '0; end
    endtask

    task automatic model_edge();
        bit ld, sm;
        ld        = frame_start && m_pend;
        sm        = m_run && sample_en && !ld;
        last_xfer = inc_valid && !m_pend;
        hv[2] = hv[1]; hp[2] = hp[1];
        hv[1] = hv[0]; hp[1] = hp[0];
        hv[0] = sm;    hp[0] = m_acc;
        if (ld) begin
            m_act = m_pv; m_pend = 0; m_acc = '0; m_run = 1;
        end else if (sm) begin
            m_acc = m_acc + m_act;
        end
        if (last_xfer) begin m_pend = 1; m_pv = inc_data; end
    endtask

    task automatic check_model();
        chk("m_ready", inc_ready, !m_pend);
        chk("m_running", running, m_run);
        chk("m_cos_valid", cos_valid, hv[2]);
        if (hv[2]) begin
            chk("m_cos_data", $signed(cos_data), exp_cos(hp[2]));
            chk("m_phase_out", phase_out, hp[2]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic drive(input logic [31:0] d, input logic iv, input logic fs, input logic se);
        inc_data = d; inc_valid = iv; frame_start = fs; sample_en = se;
    endtask

    initial begin
        tbl[0]  = '{32'h0,          0, 0, 1, 1, 0, 0, 0,      32'h0};
        tbl[1]  = '{32'h0,          0, 1, 1, 1, 0, 0, 0,      32'h0};
        tbl[2]  = '{32'h4000_0000,  1, 0, 1, 0, 0, 0, 0,      32'h0};
        tbl[3]  = '{32'h0,          0, 1, 1, 1, 1, 0, 0,      32'h0};
        tbl[4]  = '{32'h0,          0, 0, 1, 1, 1, 0, 0,      32'h0};
        tbl[5]  = '{32'h0,          0, 0, 1, 1, 1, 0, 0,      32'h0};
        tbl[6]  = '{32'h0,          0, 0, 1, 1, 1, 1, 32767,  32'h0};
        tbl[7]  = '{32'h0,          0, 0, 1, 1, 1, 1, 0,      32'h4000_0000};
        tbl[8]  = '{32'h0,          0, 0, 1, 1, 1, 1, -32767, 32'h8000_0000};
        tbl[9]  = '{32'h0,          0, 0, 0, 1, 1, 1, 0,      32'hC000_0000};
        tbl[10] = '{32'h0,          0, 0, 0, 1, 1, 1, 32767,  32'h0};
        tbl[11] = '{32'h0,          0, 0, 0, 1, 1, 0, 0,      32'h0};

        model_reset();
        #12;
        chk("rst_cos_valid", cos_valid, 0);
        chk("rst_running", running, 0);
        chk("rst_ready", inc_ready, 1);
        chk("rst_cos_data", cos_data, 0);
        chk("rst_phase_out", phase_out, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // idle rejection, then quarter-period sweep with wrap
        for (int r = 0; r < 12; r++) begin
            drive(tbl[r].inc, tbl[r].iv, tbl[r].fs, tbl[r].se);
            step();
            chk("tbl_ready", inc_ready, tbl[r].e_rdy);
            chk("tbl_running", running, tbl[r].e_run);
            chk("tbl_cos_valid", cos_valid, tbl[r].e_cv);
            if (tbl[r].e_cv) begin
                chk("tbl_cos_data", $signed(cos_data), tbl[r].e_cos);
                chk("tbl_phase_out", phase_out, tbl[r].e_ph);
            end
        end

        // backpressure: second word waits until the frame boundary frees the slot
        drive(32'd680340, 1, 0, 0);
        step();
        chk("bp_ready_after_accept", inc_ready, 0);
        drive(32'd1360680, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_ready_held", inc_ready, 0);
        end
        drive(32'd1360680, 1, 1, 0);
        step();
        chk("bp_ready_after_load", inc_ready, 1);
        drive(32'd1360680, 1, 0, 0);
        step();
        chk("bp_ready_second_taken", inc_ready, 0);
        drive(32'd0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step();
        drive(32'd0, 0, 0, 0);
        step(); step();
        chk("bp_cos_valid", cos_valid, 1);
        chk("bp_phase_step", phase_out, 32'd1360680);

        // load together with a strobe: strobe dropped, acc restarts at 0
        drive(32'd0, 0, 1, 1);
        step();
        drive(32'd0, 0, 0, 0);
        step(); step();
        chk("sc_dropped_strobe", cos_valid, 0);
        drive(32'd0, 0, 0, 1);
        step(); step(); step();
        drive(32'd0, 0, 1, 1);
        step();
        drive(32'd0, 0, 0, 1);
        step();
        drive(32'd0, 0, 0, 0);
        step(); step();
        chk("sc_empty_fs_continues", phase_out, 32'd5442720);
        chk("sc_running_kept", running, 1);

        // randomized traffic; upstream holds data while stalled
        drive(32'd0, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            if (!inc_valid || last_xfer) begin
                inc_valid = ($urandom_range(0, 3) == 0);
                inc_data  = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 32'h00FF_FFFF);
            end
            frame_start = ($urandom_range(0, 39) == 0);
            sample_en   = ($urandom_range(0, 3) != 0);
            step();
        end

        // asynchronous reset while streaming
        drive(32'd0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step();
        chk("mr_streaming", cos_valid, 1);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mr_cos_valid", cos_valid, 0);
        chk("mr_running", running, 0);
        chk("mr_ready", inc_ready, 1);
        chk("mr_cos_data", cos_data, 0);
        chk("mr_phase_out", phase_out, 0);
        drive(32'd0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(); step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/cos_nco_stage.md
Name: cos_nco_stage

Overview:
- Downstream consumer of the per-frame phase-increment generator.
- Accepts a 32-bit phase increment over a valid/ready handshake and holds it as pending.
- Applies the pending increment only at the next frame boundary, so frequency never changes mid-frame.
- Accumulates phase on each sample strobe and emits a signed cosine sample from a quarter-wave table. Output feeds the VGA waveform renderer.

Parameters:
- PHASE_W, 32, accumulator and increment width
- LUT_AW, 8, quarter-wave index bits (table holds 2^LUT_AW+1 entries)
- AMP_W, 16, signed output sample width; full scale = 2^(AMP_W-1)-1

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- inc_data  in  PHASE_W  phase increment from upstream
- inc_valid  in  1  inc_data valid
- inc_ready  out  1  stage can accept inc_data
- frame_start  in  1  one-cycle pulse at vertical sync, already synchronous to clk
- sample_en  in  1  advance phase and produce one sample
- cos_data  out  AMP_W  signed cosine sample
- cos_valid  out  1  cos_data valid, one cycle per sample_en
- phase_out  out  PHASE_W  accumulator value that produced cos_data
- running  out  1  an active increment is loaded

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all registers clear. cos_data=0, cos_valid=0, phase_out=0, running=0, inc_ready=1, pending empty, active_inc=0, pipeline valids=0.
- Handshake:
  - Transfer occurs when inc_valid && inc_ready.
  - inc_ready = !pending_full.
  - On transfer, pending_reg<=inc_data and pending_full<=1.
  - Upstream holds inc_data stable while inc_valid && !inc_ready.
- States, IDLE and RUN; running = (state==RUN):
  - IDLE: sample_en ignored, cos_valid stays 0.
  - IDLE->RUN on frame_start with pending_full.
  - RUN->RUN on frame_start with pending_full: new increment loaded.
  - RUN is kept on frame_start with pending empty: increment unchanged and accumulator NOT cleared.
  - No other transitions; only reset returns to IDLE.
- Load action, on frame_start with pending_full:
  - active_inc<=pending_reg, pending_full<=0, acc<=0.
  - This takes priority over any sample_en in the same cycle; that sample_en is dropped.
- Same-cycle transfer and frame_start: frame_start uses pending state from before the edge. A word accepted that cycle waits for the following frame_start.
- Accumulator:
  - In RUN with sample_en and no load: acc<=acc+active_inc, modulo 2^PHASE_W with silent wrap.
  - The pre-add acc value is the sample phase.
- Pipeline, latency 3 cycles from sample_en to cos_valid:
  - S1 registers the phase.
  - S2 splits it:
    - q = phase[PHASE_W-1:PHASE_W-2];
    - i = next LUT_AW bits;
    - N = 2^LUT_AW.
  - S2 folds the address: q0 T[i], q1 T[N-i] negated, q2 T[i] negated, q3 T[N-i].
  - S3 applies the sign and registers cos_data, phase_out and cos_valid.
  - Back-to-back sample_en gives back-to-back cos_valid.
- Table contents: T[k]=round((2^(AMP_W-1)-1)*cos(pi/2*k/N)), k=0..N. T[0] is full scale and T[N]=0.
- Load vs pipeline: a load does not flush the pipeline; in-flight samples complete with their old phase.
- Lower phase bits below the index are truncated.

Optional Feature:
- Macro: COS_NCO_DITHER_EN.
- When defined: a 16-bit maximal LFSR (taps 16,14,13,11) advances on each sample_en. The LFSR is seeded 0xACE1 at reset. Its low (PHASE_W-2-LUT_AW) bits are added to the sample phase before truncation in S1, spreading truncation spurs. The accumulator value itself is unaffected, and so is phase_out.
- When undefined: plain truncation and no LFSR logic.

Decomposition:
- Shared package cos_nco_pkg holds:
  - PHASE_W, LUT_AW, AMP_W defaults;
  - a quadrant enum (Q0..Q3);
  - a state enum (IDLE, RUN);
  - the LFSR seed and tap constants.
- One sub-module, cos_quarter_lut: registered-read ROM, N+1 entries, one cycle read latency. It is instantiated in S2/S3.

Test Plan:
- Reset, then sample_en held high with no increment: cos_valid stays 0, running=0, inc_ready=1.
- Quarter-period test: load 0x4000_0000, pulse frame_start, 4 sample_en. Three cycles after each sample_en, cos_data = 32767, 0, -32767, 0; phase_out = 0, 0x4000_0000, 0x8000_0000, 0xC000_0000; fifth sample wraps to 32767.
- Backpressure test: accept 680340, then hold inc_valid high with 1360680. inc_ready stays 0 until frame_start; after it, active_inc=680340 and the second word transfers next cycle.
- Same-cycle test: frame_start and sample_en together during a load. acc=0 and no cos_valid from that strobe; a frame_start with pending empty leaves acc continuing.
- Mid-run reset: deassert rst_n asynchronously during streaming. All outputs return to reset values immediately, without waiting for a clock edge.
- Dither: with COS_NCO_DITHER_EN and inc=0x0100_0000, phase_out matches the undithered build exactly and cos_data differs by at most one table step.
